// File: rtl/data_mem_access_pkg.sv
// data_mem_access_pkg: shared size/lane encodings and FSM states for the MEM-stage data-memory controller.
package data_mem_access_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_B0   = 4'b1000;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    // Size 11 decodes as word, so any size with bit 1 set needs a zero offset.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SIZE_HALF) ? a[0] : (size[1] && a != 2'b00);
    endfunction
endpackage

// File: rtl/data_mem_access_if.sv
// data_mem_access_if: request/acknowledge data-memory port; master = controller, slave = memory.
interface data_mem_access_if;
    logic        Dmem_Req;
    logic        Dmem_We;
    logic [31:0] Dmem_Addr;
    logic [3:0]  Dmem_Be;
    logic [31:0] Dmem_Wdata;
    logic        Dmem_Ack;
    logic [31:0] Dmem_Rdata;

    modport master(output Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Be, Dmem_Wdata, input Dmem_Ack, Dmem_Rdata);
    modport slave(input Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Be, Dmem_Wdata, output Dmem_Ack, Dmem_Rdata);
endinterface

// File: rtl/data_mem_access_load_align.sv
// dmem_load_align: picks the big-endian byte/half lane out of a read word and sign- or zero-extends it.
module dmem_load_align
    import data_mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  a,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    // Offset 0 is the most significant byte, so shift right by 8*(3-a).
    always_comb begin
        b = 8'(rdata >> {~a, 3'b000});
        h = a[1] ? rdata[15:0] : rdata[31:16];
        data = (size == SIZE_BYTE) ? {{24{b[7] & ~uns}}, b}
             : (size == SIZE_HALF) ? {{16{h[15] & ~uns}}, h}
             : rdata;
    end
endmodule

// File: rtl/data_mem_access.sv
// data_mem_access: MEM-stage load/store controller; one req/ack transaction per access,
// pipeline stall while outstanding, aligned/extended load result registered for WB.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  Mem_Size_MEM,
    input  logic        Mem_Unsigned_MEM,
    input  logic [31:0] ALU_Result_MEM,
    input  logic [31:0] Write_Data_MUX_MEM,
    data_mem_access_if.master dmem,
    output logic        Stall_MEM,
    output logic [31:0] Read_Data_WB,
    output logic        Load_Valid_WB,
    output logic        Misaligned_Exc,
    output logic        Bus_Err
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [1:0]  sz_q, a_q;
    logic        uns_q;
    logic [1:0]  a;
    logic        access, mis, start, done, tmo;
    logic [3:0]  be;
    logic [31:0] wdata, load_data;

    always_comb begin
        a = ALU_Result_MEM[1:0];
        access = MemRead_MEM | MemWrite_MEM;
        mis = misaligned(Mem_Size_MEM, a);
        start = state == ST_IDLE && access && !mis;
        done = state == ST_BUSY && dmem.Dmem_Ack;
        tmo = cnt == CNT_LAST;
        be = (Mem_Size_MEM == SIZE_BYTE) ? BE_B0 >> a
           : (Mem_Size_MEM == SIZE_HALF) ? (a[1] ? BE_LO : BE_HI)
           : BE_WORD;
        wdata = (Mem_Size_MEM == SIZE_BYTE) ? {4{Write_Data_MUX_MEM[7:0]}}
              : (Mem_Size_MEM == SIZE_HALF) ? {2{Write_Data_MUX_MEM[15:0]}}
              : Write_Data_MUX_MEM;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == ST_IDLE) ? (start ? ST_BUSY : ST_IDLE)
                  : ((dmem.Dmem_Ack || tmo) ? ST_IDLE : ST_BUSY);
    end

    // Stall is forced low while in reset even if the MEM inputs show an access.
    always_comb begin
        dmem.Dmem_Req = state == ST_BUSY;
        Stall_MEM = Reset_n && (start || (state == ST_BUSY && !dmem.Dmem_Ack && !tmo));
    end

    dmem_load_align u_align (
        .rdata(dmem.Dmem_Rdata),
        .size (sz_q),
        .uns  (uns_q),
        .a    (a_q),
        .data (load_data)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
            sz_q <= '0;
            a_q <= '0;
            uns_q <= 1'b0;
            dmem.Dmem_We <= 1'b0;
            dmem.Dmem_Addr <= '0;
            dmem.Dmem_Be <= '0;
            dmem.Dmem_Wdata <= '0;
            Read_Data_WB <= '0;
            Load_Valid_WB <= 1'b0;
            Misaligned_Exc <= 1'b0;
            Bus_Err <= 1'b0;
        end else begin
            cnt <= (state == ST_BUSY) ? cnt + 8'd1 : 8'd0;
            Load_Valid_WB <= done && !dmem.Dmem_We;
            Bus_Err <= state == ST_BUSY && !dmem.Dmem_Ack && tmo;
            Misaligned_Exc <= state == ST_IDLE && access && mis;
            if (start) begin
                sz_q <= Mem_Size_MEM;
                a_q <= a;
                uns_q <= Mem_Unsigned_MEM;
                dmem.Dmem_We <= MemWrite_MEM && !MemRead_MEM;
                dmem.Dmem_Addr <= {ALU_Result_MEM[31:2], 2'b00};
                dmem.Dmem_Be <= be;
                dmem.Dmem_Wdata <= wdata;
            end
            if (done && !dmem.Dmem_We) Read_Data_WB <= load_data;
            else if (state == ST_BUSY && !dmem.Dmem_Ack && tmo) Read_Data_WB <= '0;
        end
    end
endmodule
